iq_avg_snap_ctrl: RTL
=====================

Name: iq_avg_snap_ctrl

Overview:
- Sequencer for the IQ-average snapshot path.
- Takes the 32-bit control word from the snapshot-control software register and arms a capture on a rising edge of the arm bit.
- Drives accumulator clear/enable strobes over 2^k channel frames, then writes the final averaged frame into snapshot BRAM, aligned to accumulator latency.
- Sits between the control register and the accumulator/snapshot BRAM, in the user_clk domain.

Parameters:
- ADDR_W, 9: log2 channels per frame; snapshot depth is 2^ADDR_W.
- LOG2_MAX_AVG, 8: maximum log2 of frames averaged.
- ACC_LAT, 2: cycles from acc_en to valid accumulator output; must be ≥ 1.

Ports:
- user_clk  in  1  single clock domain.
- user_rst  in  1  synchronous, active-high reset.
- ctrl_word  in  32  register value. Bit0 = arm (edge-triggered); bit1 = continuous re-arm; bits[11:8] = log2 average count.
- data_valid  in  1  one channel sample present this cycle.
- frame_sync  in  1  qualifies data_valid; marks channel 0 of a frame.
- acc_en  out  1  accumulate the current sample.
- acc_clr  out  1  with acc_en: load instead of add (first frame).
- ch_addr  out  ADDR_W  channel index of the current sample.
- snap_we  out  1  write strobe to snapshot BRAM.
- snap_addr  out  ADDR_W  BRAM write address.
- busy  out  1  capture in progress.
- done  out  1  last capture complete.
- sync_err  out  1  sticky: frame length mismatch.
- arm_ignored  out  1  sticky: arm seen while busy.

Behaviour:
- Reset state:
  - All outputs 0; state IDLE; delay line cleared.
  - Arm-edge register resets to 1, so a bit0 already high at reset does not arm.
- Arm:
  - arm = ctrl_word[0] & ~bit0_q.
  - N = 2^min(ctrl_word[11:8], LOG2_MAX_AVG). The field is latched at arm and ignored until the next arm.
- States:
  - IDLE: on arm → WAIT_SYNC; busy=1, done=0.
  - WAIT_SYNC: on data_valid & frame_sync → ACCUM, frame 0, channel 0 processed this same cycle.
  - ACCUM: each data_valid asserts acc_en combinationally in the same cycle.
    - acc_clr=1 throughout frame 0.
    - ch_addr = channel counter; the counter increments per valid and wraps at 2^ADDR_W − 1.
    - frame_cnt increments at wrap.
    - When entering frame N−1 → LAST (for N=1, frame 0 is LAST and acc_clr is also 1).
  - LAST: same as ACCUM, plus each valid pushes {1, ch_addr} into an ACC_LAT-deep delay line. snap_we/snap_addr appear exactly ACC_LAT cycles after the matching acc_en.
    - After channel 2^ADDR_W − 1 → DRAIN.
  - DRAIN: wait until the delay line is empty, then → IDLE with done=1, busy=0.
    - If ctrl_word[1]=1 → WAIT_SYNC directly; done pulses for 1 cycle, busy stays 1.
- Frame_sync handling:
  - frame_sync with channel counter ≠ 0 in ACCUM/LAST: set sync_err, abort to IDLE, done stays 0.
  - Delay-line entries already queued still drain; no new entries are pushed.
  - frame_sync in IDLE/DRAIN is ignored.
- Arm while busy: ignored; sets arm_ignored. Sticky flags clear only on the next accepted arm or on reset.
- data_valid without frame_sync in WAIT_SYNC is ignored.
- Reset mid-capture: everything returns to reset state in the next cycle; pending snap_we entries are discarded.

Optional Feature:
- Macro IQ_AVG_SNAP_TIMESTAMP_EN.
- Defined:
  - Adds output start_ts [31:0] and an internal free-running 32-bit cycle counter (reset 0, wraps).
  - start_ts latches the counter on the WAIT_SYNC→ACCUM transition and holds it until the next such transition.
  - start_ts resets to 0.
- Undefined: no port, no counter; behaviour otherwise identical.

Decomposition:
- Package iq_avg_snap_pkg holds:
  - State enum (IDLE, WAIT_SYNC, ACCUM, LAST, DRAIN).
  - Control-word field constants: ARM_BIT=0, CONT_BIT=1, AVG_LSB=8, AVG_MSB=11.
- Sub-module iq_avg_we_delay: parameterised ACC_LAT-stage shift register of {valid, addr} with synchronous clear and an empty flag.

Test Plan:
- Write-enable alignment: ADDR_W=3, ACC_LAT=2, ctrl_word 0→0x101 (N=2), continuous data_valid, frame_sync every 8 → acc_clr high for 8 cycles, then acc_en-only for 8. snap_we high 8 cycles starting 2 cycles after the first LAST-frame acc_en, addresses 0..7. done=1 after the last write.
- Clamp and continuous mode: ctrl_word=0x0F03 with LOG2_MAX_AVG=2 → N clamps to 4. Continuous re-arm gives a 1-cycle done pulse per capture and busy never drops.
- Sync error: frame_sync arriving at channel 5 mid-ACCUM → sync_err=1, state IDLE, done=0, no snap_we.
- Spurious arm: hold bit0=1 through reset → no arm. Toggle 0→1 while busy → arm_ignored=1 and capture unaffected.
- Reset mid-capture: user_rst during LAST with 2 writes queued → no snap_we after reset; all outputs 0.
- Timestamp (IQ_AVG_SNAP_TIMESTAMP_EN): first sync 100 cycles after reset → start_ts=100 (±edge convention fixed at 100).

Source files
------------

// File: rtl/iq_avg_snap_pkg.sv
// Shared types and control-word field positions for the IQ-average snapshot sequencer.
package iq_avg_snap_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SYNC, ACCUM, LAST, DRAIN} state_t;

  localparam int ARM_BIT  = 0;
  localparam int CONT_BIT = 1;
  localparam int AVG_LSB  = 8;
  localparam int AVG_MSB  = 11;
  localparam int AVG_W    = AVG_MSB - AVG_LSB + 1;

  // Requested log2 average count, limited to what the accumulator supports.
  function automatic logic [AVG_W-1:0] clamp_avg(input logic [AVG_W-1:0] f, input int max_l2);
    logic [31:0] m;
    m = max_l2;
    return (int'(f) > max_l2) ? m[AVG_W-1:0] : f;
  endfunction
endpackage

// File: rtl/iq_avg_snap_ctrl_if.sv
// Sample-stream, accumulator and snapshot-BRAM signals of the snapshot sequencer.
interface iq_avg_snap_ctrl_if #(parameter int ADDR_W = 9);
  logic              data_valid;
  logic              frame_sync;
  logic              acc_en;
  logic              acc_clr;
  logic [ADDR_W-1:0] ch_addr;
  logic              snap_we;
  logic [ADDR_W-1:0] snap_addr;

  modport master (input data_valid, frame_sync,
                  output acc_en, acc_clr, ch_addr, snap_we, snap_addr);
  modport slave  (output data_valid, frame_sync,
                  input acc_en, acc_clr, ch_addr, snap_we, snap_addr);
endinterface

// File: rtl/iq_avg_we_delay.sv
// ACC_LAT-stage {valid, addr} delay line aligning snapshot writes to accumulator output.
module iq_avg_we_delay #(
  parameter int ACC_LAT = 2,
  parameter int ADDR_W  = 9
) (
  input  logic              user_clk,
  input  logic              clr,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              empty
);
  logic [ACC_LAT-1:0]             vld_pipe;
  logic [ACC_LAT-1:0][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge user_clk) begin
    if (clr) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= push;
      addr_pipe[0] <= push_addr;
      for (int i = 1; i < ACC_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign we    = vld_pipe[ACC_LAT-1];
  assign addr  = addr_pipe[ACC_LAT-1];
  assign empty = ~|vld_pipe;
endmodule

// File: rtl/iq_avg_snap_ctrl.sv
// IQ-average snapshot sequencer: arm, accumulate 2^k frames, write the final frame to BRAM.
// Optional IQ_AVG_SNAP_TIMESTAMP_EN adds start_ts, the cycle count at capture start.
module iq_avg_snap_ctrl
  import iq_avg_snap_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int LOG2_MAX_AVG = 8,
  parameter int ACC_LAT      = 2
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         ctrl_word,
  iq_avg_snap_ctrl_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                sync_err,
  output logic                arm_ignored
`ifdef IQ_AVG_SNAP_TIMESTAMP_EN
  , output logic [31:0]       start_ts
`endif
);
  localparam int FW = LOG2_MAX_AVG + 1;
  localparam logic [ADDR_W-1:0] CH_MAX = '1;

  state_t            state, state_nxt;
  logic              bit0_q, arm, cont;
  logic [AVG_W-1:0]  log2n;
  logic [FW-1:0]     frame_cnt, n_m1;
  logic [ADDR_W-1:0] ch_cnt, ch_addr;
  logic              first_sync, sync_bad, ch_wrap;
  logic              acc_en, acc_clr, push, dl_empty;
  logic              unused_ctrl;

  assign unused_ctrl = ^{ctrl_word[31:12], ctrl_word[7:2]};
  assign arm         = ctrl_word[ARM_BIT] & ~bit0_q;
  assign cont        = ctrl_word[CONT_BIT];
  assign n_m1        = (FW'(1) << log2n) - FW'(1);
  assign ch_wrap     = (ch_cnt == CH_MAX);
  assign first_sync  = (state == WAIT_SYNC) & bus.data_valid & bus.frame_sync;
  assign sync_bad    = ((state == ACCUM) | (state == LAST)) & bus.data_valid
                     & bus.frame_sync & (ch_cnt != '0);

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (arm) state_nxt = WAIT_SYNC;
      WAIT_SYNC: if (first_sync) state_nxt = (log2n == '0) ? LAST : ACCUM;
      ACCUM:     if (sync_bad) state_nxt = IDLE;
                 else if (bus.data_valid && ch_wrap && (frame_cnt + FW'(1) == n_m1))
                   state_nxt = LAST;
      LAST:      if (sync_bad) state_nxt = IDLE;
                 else if (bus.data_valid && ch_wrap) state_nxt = DRAIN;
      DRAIN:     if (dl_empty) state_nxt = cont ? WAIT_SYNC : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Channel 0 of frame 0 is consumed in the same cycle the sync is recognised.
  always_comb begin
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    ch_addr = '0;
    push    = 1'b0;
    busy    = (state != IDLE);
    case (state)
      WAIT_SYNC: begin
        acc_en  = first_sync;
        acc_clr = first_sync;
        push    = first_sync & (log2n == '0);
      end
      ACCUM, LAST: begin
        acc_en  = bus.data_valid & ~sync_bad;
        acc_clr = acc_en & (frame_cnt == '0);
        ch_addr = ch_cnt;
        push    = acc_en & (state == LAST);
      end
      default: ;
    endcase
  end

  assign bus.acc_en  = acc_en;
  assign bus.acc_clr = acc_clr;
  assign bus.ch_addr = ch_addr;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      bit0_q      <= 1'b1;
      log2n       <= '0;
      ch_cnt      <= '0;
      frame_cnt   <= '0;
      done        <= 1'b0;
      sync_err    <= 1'b0;
      arm_ignored <= 1'b0;
    end else begin
      bit0_q <= ctrl_word[ARM_BIT];
      if (arm && state == IDLE) begin
        log2n       <= clamp_avg(ctrl_word[AVG_MSB:AVG_LSB], LOG2_MAX_AVG);
        sync_err    <= 1'b0;
        arm_ignored <= 1'b0;
      end else if (arm) begin
        arm_ignored <= 1'b1;
      end
      if (sync_bad) sync_err <= 1'b1;
      if (first_sync) begin
        ch_cnt    <= ADDR_W'(1);
        frame_cnt <= '0;
      end else if (acc_en && (state == ACCUM || state == LAST)) begin
        ch_cnt <= ch_cnt + ADDR_W'(1);
        if (ch_wrap) frame_cnt <= frame_cnt + FW'(1);
      end
      // Held in IDLE; a continuous re-arm leaves DRAIN for WAIT_SYNC, so this is a 1-cycle pulse.
      if (state == DRAIN && dl_empty) done <= 1'b1;
      else if (state != IDLE || arm)  done <= 1'b0;
    end
  end

  iq_avg_we_delay #(.ACC_LAT(ACC_LAT), .ADDR_W(ADDR_W)) u_dly (
    .user_clk  (user_clk),
    .clr       (user_rst),
    .push      (push),
    .push_addr (ch_addr),
    .we        (bus.snap_we),
    .addr      (bus.snap_addr),
    .empty     (dl_empty)
  );

`ifdef IQ_AVG_SNAP_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ts_cnt   <= '0;
      start_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (first_sync) start_ts <= ts_cnt;
    end
  end
`endif
endmodule
